// File: rtl/light_pkg.sv
// Shared codes and FSM states for the light_control -> light_pwm_driver chain.
// Also provides the color-to-channel enable mapping.
package light_pkg;

    typedef enum logic [1:0] {
        LUM_OFF  = 2'b00,
        LUM_LOW  = 2'b01,
        LUM_MID  = 2'b10,
        LUM_HIGH = 2'b11
    } lum_t;

    typedef enum logic [1:0] {
        COL_WHITE = 2'b00,
        COL_RED   = 2'b01,
        COL_GREEN = 2'b10,
        COL_BLUE  = 2'b11
    } col_t;

    typedef enum logic [2:0] {
        STEADY   = 3'd0,
        RAMP     = 3'd1,
        FADE_OUT = 3'd2,
        SWITCH   = 3'd3,
        FADE_IN  = 3'd4
    } state_t;

    // Channel enables ordered {r, g, b}.
    function automatic logic [2:0] color_enable(input col_t c);
        case (c)
            COL_WHITE: color_enable = 3'b111;
            COL_RED:   color_enable = 3'b100;
            COL_GREEN: color_enable = 3'b010;
            default:   color_enable = 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel_gen.sv
// Free-running PWM counter with a per-period shadow duty.
// Drives three registered channel outputs gated by their enables.
module pwm_channel_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [2:0]          enable,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b
);

    // Period is 2^PWM_BITS-1 so that a full-scale duty reads as always on.
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PWM_BITS-1:0] counter;
    logic [PWM_BITS-1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            shadow  <= '0;
            pwm_r   <= 1'b0;
            pwm_g   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            {pwm_r, pwm_g, pwm_b} <= enable & {3{counter < shadow}};
            if (counter == CNT_LAST) begin
                counter <= '0;
                shadow  <= duty;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

// File: rtl/light_pwm_driver.sv
// Ramps LED duty toward the luminosity target and sequences color changes
// as fade-out / switch / fade-in; PWM generation is delegated to pwm_channel_gen.
module light_pwm_driver
    import light_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_DIV  = 16,
    parameter int DUTY_LOW  = 64,
    parameter int DUTY_MID  = 160,
    parameter int DUTY_HIGH = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          luminosity,
    input  logic [1:0]          color,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy,
    output state_t              state
);

    localparam int PRE_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    lum_t                lum_q;
    col_t                col_q;
    col_t                active_q, active_d;
    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_up, duty_dn, duty_toward;
    logic                color_changed;

    assign tick          = (presc == PRE_LAST);
    assign color_changed = (col_q != active_q);

    always_comb begin
        case (lum_q)
            LUM_LOW:  target = PWM_BITS'(DUTY_LOW);
            LUM_MID:  target = PWM_BITS'(DUTY_MID);
            LUM_HIGH: target = PWM_BITS'(DUTY_HIGH);
            default:  target = '0;
        endcase
    end

    // Saturating single steps; ramps re-read target every tick so it can move mid-ramp.
    assign duty_up     = (duty_q == DUTY_MAX) ? duty_q : duty_q + 1'b1;
    assign duty_dn     = (duty_q == '0) ? duty_q : duty_q - 1'b1;
    assign duty_toward = (duty_q < target) ? duty_up :
                         (duty_q > target) ? duty_dn : duty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lum_q    <= LUM_OFF;
            col_q    <= COL_WHITE;
            active_q <= COL_WHITE;
            state_q  <= STEADY;
            duty_q   <= '0;
            presc    <= '0;
        end else begin
            lum_q    <= lum_t'(luminosity);
            col_q    <= col_t'(color);
            active_q <= active_d;
            state_q  <= state_d;
            duty_q   <= duty_d;
            presc    <= tick ? '0 : presc + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        active_d = active_q;
        case (state_q)
            STEADY: begin
                if (color_changed)         state_d = FADE_OUT;
                else if (duty_q != target) state_d = RAMP;
            end
            RAMP: begin
                if (color_changed)         state_d = FADE_OUT;
                else if (duty_q == target) state_d = STEADY;
                else if (tick)             duty_d  = duty_toward;
            end
            FADE_OUT: begin
                if (duty_q == '0) state_d = SWITCH;
                else if (tick)    duty_d  = duty_dn;
            end
            SWITCH: begin
                // Latest col_q wins, so presses made during the fade collapse here.
                active_d = col_q;
                state_d  = FADE_IN;
            end
            FADE_IN: begin
                if (color_changed)                          state_d = FADE_OUT;
                else if (target == '0 || duty_q == target)  state_d = STEADY;
                else if (tick)                              duty_d  = duty_toward;
            end
            default: state_d = STEADY;
        endcase
    end

    assign duty  = duty_q;
    assign busy  = (state_q != STEADY);
    assign state = state_q;

    pwm_channel_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty_q),
        .enable (color_enable(active_q)),
        .pwm_r  (pwm_r),
        .pwm_g  (pwm_g),
        .pwm_b  (pwm_b)
    );

endmodule

// File: doc/light_pwm_driver.md
Name: light_pwm_driver

Overview:
- Downstream stage of light_control. Consumes its 2-bit luminosity and 2-bit color codes and drives three LED PWM outputs (red, green, blue).
- Ramps duty gradually toward the luminosity target so brightness changes are smooth.
- On a color change, fades the lamp out, switches channels, then fades back in.

Parameters:
- PWM_BITS, 8, PWM counter and duty width; PWM period is 2^PWM_BITS-1 cycles.
- RAMP_DIV, 16, clock cycles per ±1 duty ramp step; must be ≥2.
- DUTY_LOW, 64, target duty for LOW luminosity.
- DUTY_MID, 160, target duty for MID luminosity.
- DUTY_HIGH, 255, target duty for HIGH luminosity; must be ≤2^PWM_BITS-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- luminosity  in  2  00 OFF, 01 LOW, 10 MID, 11 HIGH
- color  in  2  00 WHITE (R+G+B), 01 RED, 10 GREEN, 11 BLUE
- pwm_r  out  1  red LED drive
- pwm_g  out  1  green LED drive
- pwm_b  out  1  blue LED drive
- duty  out  PWM_BITS  current ramped duty, pre-shadow
- busy  out  1  high whenever state ≠ STEADY

Behaviour:
- Reset (one clk edge with reset=1), all values synchronous:
  - pwm_r/g/b=0, duty=0, busy=0, state=STEADY
  - active color=WHITE; input registers lum_q=OFF, col_q=WHITE
  - PWM counter=0, prescaler=0, shadow duty=0
  - reset asserted mid-fade aborts immediately to these values
- Inputs are registered once (lum_q, col_q): one cycle input latency.
- target = lookup(lum_q): OFF→0, LOW→DUTY_LOW, MID→DUTY_MID, HIGH→DUTY_HIGH.
- Prescaler counts 0..RAMP_DIV-1 and wraps; tick=1 on the wrap cycle. Duty changes only on tick.
- States:
  - STEADY: if col_q≠active color → FADE_OUT. Else if duty≠target → RAMP.
  - RAMP: on tick, duty steps ±1 toward target; it is re-evaluated every tick, so target changes mid-ramp retarget live. When duty==target → STEADY. Color change detected → FADE_OUT, taking priority over the luminosity ramp.
  - FADE_OUT: on tick, duty-1. At duty==0 → SWITCH on the next clk. If duty is already 0, go to SWITCH on the next clk.
  - SWITCH: one cycle; active color ← col_q; → FADE_IN.
  - FADE_IN: on tick, duty steps ±1 toward target.
    - duty==target → STEADY.
    - col_q≠active color → FADE_OUT, from the current duty.
    - Target of 0 (OFF) → STEADY immediately.
- Simultaneous color and luminosity change: fade out, switch, fade in to the new target.
- Color change while in FADE_OUT: no restart; SWITCH samples the latest col_q.
- Rapid button presses therefore collapse to a single fade cycle ending at the final color.
- PWM:
  - Counter runs 0..2^PWM_BITS-2 and wraps.
  - Shadow duty loads from duty when counter==2^PWM_BITS-2, so duty takes effect at the start of the next period.
  - Channel output is registered: out = enable & (counter < shadow). Shadow=0 gives constantly low; shadow=2^PWM_BITS-1 gives constantly high.
  - Channel enable from active color: WHITE→R,G,B; RED→R; GREEN→G; BLUE→B.
- Duty arithmetic saturates: never steps below 0 or above 2^PWM_BITS-1.

Decomposition:
- Package light_pkg holds:
  - luminosity codes (LUM_OFF, LUM_LOW, LUM_MID, LUM_HIGH)
  - color codes (COL_WHITE, COL_RED, COL_GREEN, COL_BLUE)
  - FSM state enum (STEADY, RAMP, FADE_OUT, SWITCH, FADE_IN)
  - light_control also imports the luminosity and color codes.
- One sub-module: pwm_channel_gen. It holds the PWM counter and shadow register, takes duty plus the 3-bit enable, and emits the registered pwm_r/g/b. The ramp FSM stays in the top level.

Test Plan (RAMP_DIV=4, PWM_BITS=8, defaults otherwise):
- Reset then luminosity=11, color=00 → busy=1 and duty rises by 1 every 4 cycles. Duty reaches 255 after 1020 ticks-cycles (±4), then busy=0. After the next period boundary, pwm_r/g/b all constantly 1.
- From steady HIGH/WHITE, set luminosity=01 → duty ramps down to 64 and stops. Measured pwm_r high count per 255-cycle period = 64.
- From steady MID/WHITE, set color=01 → duty falls to 0, then SWITCH for one cycle. Duty climbs back to 160 with only pwm_r toggling; pwm_g=pwm_b=0.
- During FADE_OUT, pulse color 01→10→11 within 30 cycles → exactly one SWITCH occurs, active color ends BLUE, and only pwm_b is active.
- luminosity=00 from HIGH → duty reaches 0 and stays; all PWM outputs 0 for a full period; busy=0.
- Assert reset for one cycle mid FADE_IN at duty≈100 → next cycle duty=0, busy=0, all PWM outputs 0, active color WHITE.
